dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the KGPRISC data-memory interface: accepts load/store requests from the CPU and returns read data or completion.
- Holds a word-organised RAM with 4-bit byte-lane write enables; the lane encoding matches the CPU's store-enable output.
- Adds a valid/ready request handshake and a programmable wait-state counter, so the CPU can later move to a multi-cycle memory model.
- Sits between kgp_risc and top, replacing the direct data_memory hookup.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 1, extra cycles inserted between request accept and the RAM access (0..15).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address; bits [1:0] must be 0.
- req_wea  in  4  byte-lane write enables; 4'b0000 = load, nonzero = store; bit i writes byte lane i, bits [8i+7:8i].
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access fault, qualified by rsp_valid.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, req_ready=1 on the following cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - RAM contents are untouched unless the optional feature is enabled.
- rst has priority over every other event. Reset mid-operation aborts the request: no RAM write occurs, even if the access edge coincides with rst, and no response is produced.
- FSM IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req_valid && req_ready, capture addr/wea/wdata, load counter = WAIT_CYCLES, go to WAIT.
  - WAIT: req_ready=0.
    - Counter nonzero: decrement it.
    - Counter == 0: perform the access at this edge, register the response, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE. No back-pressure on the response; the CPU must take it.
- Latency: if accept happens at edge T, then the access occurs at edge T+1+WAIT_CYCLES and rsp_valid is high in the cycle after that edge.
- Throughput: one request per WAIT_CYCLES+3 cycles. req_valid is ignored outside IDLE.
- Fault checks, evaluated on the captured request:
  - Misaligned if addr[1:0] != 0.
  - Out of range if addr[31:ADDR_W+2] != 0.
  - On a fault: no write, rsp_rdata=0, rsp_err=1, same timing as a normal access.
- Load: rsp_rdata = RAM[addr[ADDR_W+1:2]], i.e. the contents before any later write. rsp_err=0.
- Store: only the enabled lanes are updated at the access edge; disabled lanes keep their old value. rsp_rdata=0, rsp_err=0.
- Wrap-around: none. Addresses at or beyond the RAM size fault; they never alias.
- Response registers hold their last values while rsp_valid=0. The bench checks them only when rsp_valid=1.

Optional Feature:
- Macro: DMEM_RESET_CLEAR_EN.
- Defined:
  - After rst deasserts, the FSM enters state CLEAR and writes 0 to one word per cycle, from word 0 to word 2**ADDR_W-1.
  - req_ready=0 throughout CLEAR; IDLE is entered after the last word is cleared.
  - Reasserting rst during CLEAR restarts clearing from word 0.
- Undefined: no CLEAR state. RAM is unaffected by reset, and req_ready=1 the first cycle after rst deasserts.

Test Plan:
- WAIT_CYCLES=1: store addr 0x10, wea 4'b1111, wdata 0xDEADBEEF, then load 0x10.
  - Required: rsp_valid for the store arrives 2 edges after accept with rsp_err=0.
  - Required: the load returns 0xDEADBEEF.
- Byte lanes: word 0x20 holds 0x11223344; store wea 4'b0101, wdata 0xAABBCCDD; load 0x20 returns 0x11BB33DD.
- Faults: load 0x13 returns rsp_err=1, rsp_rdata=0. Store to 0x1000 with ADDR_W=10 gives rsp_err=1 and a subsequent load of 0x0 is unchanged.
- Handshake: hold req_valid=1 continuously with WAIT_CYCLES=0. Exactly one request is accepted every 3 cycles, req_ready=0 in WAIT and RESP, and rsp_valid pulses are 1 cycle wide.
- Reset mid-operation: accept a store to 0x40 (old value 0x5), assert rst on the access edge.
  - Required: no rsp_valid, and a load of 0x40 after reset returns 0x5.
- DMEM_RESET_CLEAR_EN, ADDR_W=4: preload nonzero data, pulse rst.
  - Required: req_ready stays low for 16 cycles, then loads of 0x0 through 0x3C all return 0.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with valid/ready request handshake and wait states
// Optional feature macro: DMEM_RESET_CLEAR_EN (zero the whole RAM after reset)
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_wea,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

`ifdef DMEM_RESET_CLEAR_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, CLEAR = 2'd3} state_t;
   localparam state_t RESET_STATE = CLEAR;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
   localparam state_t RESET_STATE = IDLE;
`endif

   state_t              state;
   state_t              next_state;
   logic [3:0]          wait_cnt;
   logic [31:0]         cap_addr;
   logic [3:0]          cap_wea;
   logic [31:0]         cap_wdata;
   logic [31:0]         mem [DEPTH];
   logic [ADDR_W-1:0]   word_idx;
   logic                fault;
   logic                access;
   logic                do_write;
`ifdef DMEM_RESET_CLEAR_EN
   logic [ADDR_W-1:0]   clr_idx;
`endif

   // Decode of the captured request; faults are judged on the latched copy, not the live bus
   assign word_idx = cap_addr[ADDR_W+1:2];
   assign fault    = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (ADDR_W + 2)) != 32'd0);
   assign access   = (state == WAIT) && (wait_cnt == 4'd0);
   assign do_write = access && (cap_wea != 4'b0000) && !fault;

   // State register; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) state <= RESET_STATE;
      else     state <= next_state;
   end

   // Next-state and handshake decode
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) next_state = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 4'd0) next_state = RESP;
         end
         RESP: next_state = IDLE;
`ifdef DMEM_RESET_CLEAR_EN
         CLEAR: begin
            if (&clr_idx) next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Request capture and wait-state countdown
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= 4'd0;
         cap_addr  <= 32'd0;
         cap_wea   <= 4'b0000;
         cap_wdata <= 32'd0;
      end else if (state == IDLE && req_valid) begin
         wait_cnt  <= WAIT_INIT;
         cap_addr  <= req_addr;
         cap_wea   <= req_wea;
         cap_wdata <= req_wdata;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

`ifdef DMEM_RESET_CLEAR_EN
   // Clear pointer restarts from word 0 on every reset
   always_ff @(posedge clk) begin
      if (rst)                 clr_idx <= '0;
      else if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
   end
`endif

   // RAM write port: byte-lane stores, or zero-fill while clearing; never while in reset
   always_ff @(posedge clk) begin
      if (!rst) begin
`ifdef DMEM_RESET_CLEAR_EN
         if (state == CLEAR) begin
            mem[clr_idx] <= 32'd0;
         end else
`endif
         if (do_write) begin
            for (int i = 0; i < 4; i++) begin
               if (cap_wea[i]) mem[word_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
         end
      end
   end

   // Response registers; load data is the pre-write RAM contents, held between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= access;
         if (access) begin
            rsp_err   <= fault;
            rsp_rdata <= (fault || cap_wea != 4'b0000) ? 32'd0 : mem[word_idx];
         end
      end
   end

endmodule
